// File: rtl/picorv_mem_sequencer.sv
// Sequences picorv32 native memory requests onto the HPDcache core port or the uart_ram MMIO window,
// draining the HPDcache write buffer on an ebreak fetch. Optional watchdog: define PMS_TIMEOUT_EN.
module picorv_mem_sequencer #(
  parameter logic [31:0] PhysMemLimit = 32'h0002_0000,
  parameter logic [31:0] MmioBase     = 32'h1000_0000,
  parameter logic [31:0] MmioMask     = 32'hF000_0000,
  parameter logic [31:0] EbreakInstr  = 32'h0010_0073
`ifdef PMS_TIMEOUT_EN
  , parameter int unsigned TimeoutCycles = 1024
`endif
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cpu_valid_i,
  input  logic        cpu_instr_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [3:0]  cpu_wstrb_i,
  output logic        cpu_ready_o,
  output logic [31:0] cpu_rdata_o,
  output logic        cache_req_valid_o,
  input  logic        cache_req_ready_i,
  output logic [31:0] cache_req_addr_o,
  output logic [31:0] cache_req_wdata_o,
  output logic [3:0]  cache_req_be_o,
  output logic        cache_req_store_o,
  output logic        cache_req_unc_o,
  input  logic        cache_rsp_valid_i,
  input  logic [31:0] cache_rsp_rdata_i,
  output logic        mmio_valid_o,
  input  logic        mmio_ready_i,
  input  logic [31:0] mmio_rdata_i,
  output logic        wbuf_flush_o,
  input  logic        wbuf_empty_i,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ_C   = 3'd1,
    ST_REQ_M   = 3'd2,
    ST_WAIT_C  = 3'd3,
    ST_FLUSH_P = 3'd4,
    ST_FLUSH_W = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  state_t      state_r;
  logic        instr_r;
  logic [31:0] data_r;
  logic        mmio_hit_s;
  logic        rsp_take_s;
  logic        rsp_ebreak_s;
  logic        progress_s;
  logic        timeout_s;

  // Request decode and "the current wait state is about to advance" detection
  always_comb begin
    mmio_hit_s   = ((cpu_addr_i & MmioMask) == MmioBase);
    rsp_ebreak_s = instr_r && (cache_rsp_rdata_i == EbreakInstr);
    // A response in the accept cycle counts as the response; anywhere outside REQ_C/WAIT_C it is dropped
    rsp_take_s   = ((state_r == ST_REQ_C) && cache_req_ready_i && cache_rsp_valid_i) ||
                   ((state_r == ST_WAIT_C) && cache_rsp_valid_i);
    case (state_r)
      ST_REQ_C:   progress_s = cache_req_ready_i;
      ST_WAIT_C:  progress_s = cache_rsp_valid_i;
      ST_REQ_M:   progress_s = mmio_ready_i;
      ST_FLUSH_W: progress_s = wbuf_empty_i;
      default:    progress_s = 1'b0;
    endcase
  end

`ifdef PMS_TIMEOUT_EN
  localparam int unsigned CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

  logic [CntW-1:0] cnt_r;
  logic            counting_s;

  // Watchdog expiry: last counting cycle reached without progress being made
  always_comb begin
    counting_s = (state_r == ST_REQ_C) || (state_r == ST_WAIT_C) ||
                 (state_r == ST_REQ_M) || (state_r == ST_FLUSH_W);
    timeout_s  = counting_s && (cnt_r == CntW'(TimeoutCycles - 32'd1));
  end

  // Watchdog counter, restarted whenever the sequencer is idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= {CntW{1'b0}};
    end else if (state_r == ST_IDLE) begin
      cnt_r <= {CntW{1'b0}};
    end else if (counting_s && !timeout_s) begin
      cnt_r <= cnt_r + {{(CntW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end
`else
  assign timeout_s = 1'b0;
  assign err_o     = 1'b0;
`endif

  // Transaction FSM with all outputs registered
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r           <= ST_IDLE;
      instr_r           <= 1'b0;
      data_r            <= 32'h0000_0000;
      cpu_ready_o       <= 1'b0;
      cpu_rdata_o       <= 32'h0000_0000;
      cache_req_valid_o <= 1'b0;
      cache_req_addr_o  <= 32'h0000_0000;
      cache_req_wdata_o <= 32'h0000_0000;
      cache_req_be_o    <= 4'h0;
      cache_req_store_o <= 1'b0;
      cache_req_unc_o   <= 1'b0;
      mmio_valid_o      <= 1'b0;
      wbuf_flush_o      <= 1'b0;
      busy_o            <= 1'b0;
`ifdef PMS_TIMEOUT_EN
      err_o             <= 1'b0;
`endif
    end else begin
      cpu_ready_o  <= 1'b0;
      cpu_rdata_o  <= 32'h0000_0000;
      wbuf_flush_o <= 1'b0;
      if (timeout_s && !progress_s) begin
        state_r           <= ST_DONE;
        cache_req_valid_o <= 1'b0;
        mmio_valid_o      <= 1'b0;
        cpu_ready_o       <= 1'b1;
        cpu_rdata_o       <= 32'hDEAD_BEEF;
`ifdef PMS_TIMEOUT_EN
        err_o             <= 1'b1;
`endif
      end else if (rsp_take_s) begin
        cache_req_valid_o <= 1'b0;
        data_r            <= cache_rsp_rdata_i;
        if (rsp_ebreak_s) begin
          state_r      <= ST_FLUSH_P;
          wbuf_flush_o <= 1'b1;
        end else begin
          state_r     <= ST_DONE;
          cpu_ready_o <= 1'b1;
          cpu_rdata_o <= cache_req_store_o ? 32'h0000_0000 : cache_rsp_rdata_i;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (cpu_valid_i) begin
              instr_r           <= cpu_instr_i;
              cache_req_addr_o  <= cpu_addr_i;
              cache_req_wdata_o <= cpu_wdata_i;
              cache_req_be_o    <= cpu_wstrb_i;
              cache_req_store_o <= |cpu_wstrb_i;
              cache_req_unc_o   <= (cpu_addr_i >= PhysMemLimit);
              busy_o            <= 1'b1;
              if (mmio_hit_s) begin
                state_r      <= ST_REQ_M;
                mmio_valid_o <= 1'b1;
              end else begin
                state_r           <= ST_REQ_C;
                cache_req_valid_o <= 1'b1;
              end
            end
          end
          ST_REQ_C: begin
            if (cache_req_ready_i) begin
              cache_req_valid_o <= 1'b0;
              state_r           <= ST_WAIT_C;
            end
          end
          ST_WAIT_C: begin
            state_r <= ST_WAIT_C;
          end
          ST_REQ_M: begin
            if (mmio_ready_i) begin
              mmio_valid_o <= 1'b0;
              data_r       <= mmio_rdata_i;
              state_r      <= ST_DONE;
              cpu_ready_o  <= 1'b1;
              cpu_rdata_o  <= cache_req_store_o ? 32'h0000_0000 : mmio_rdata_i;
            end
          end
          ST_FLUSH_P: begin
            state_r <= ST_FLUSH_W;
          end
          ST_FLUSH_W: begin
            if (wbuf_empty_i) begin
              state_r     <= ST_DONE;
              cpu_ready_o <= 1'b1;
              cpu_rdata_o <= cache_req_store_o ? 32'h0000_0000 : data_r;
            end
          end
          ST_DONE: begin
            state_r <= ST_IDLE;
            busy_o  <= 1'b0;
          end
          default: begin
            state_r           <= ST_IDLE;
            cache_req_valid_o <= 1'b0;
            mmio_valid_o      <= 1'b0;
            busy_o            <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
